// File: rtl/stop_watch_ctrl.sv
// stop_watch_ctrl: key conditioning and run/pause/lap control for the
// HH:MM:SS stopwatch counter chain. Three raw active-low buttons are
// synchronized and debounced. Each accepted press becomes a one-cycle event
// that drives the run state machine. The block produces the once-per-second
// count enable, the clear pulse and the display lap-hold level.
module stop_watch_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned TICK_DIV        = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start_n,
  input  logic       key_clear_n,
  input  logic       key_lap_n,
  output logic       count_en,
  output logic       clear,
  output logic       lap_hold,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } state_t;

  localparam int unsigned NUM_KEYS  = 3;
  localparam int unsigned KEY_START = 0;
  localparam int unsigned KEY_CLEAR = 1;
  localparam int unsigned KEY_LAP   = 2;

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned DIV_W = $clog2(TICK_DIV);

  // The counter flips the debounced level on the sample that would bring it
  // to DEBOUNCE_CYCLES. A level is accepted after exactly that many
  // consecutive differing samples.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  // ---------------------------------------------------------------------
  // Key conditioning
  // ---------------------------------------------------------------------
  logic [NUM_KEYS-1:0] key_raw;

  logic [NUM_KEYS-1:0] sync1_q, sync1_d;
  logic [NUM_KEYS-1:0] sync2_q, sync2_d;
  logic [NUM_KEYS-1:0] db_q, db_d;
  logic [NUM_KEYS-1:0] db_prev_q, db_prev_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];

  assign key_raw = {key_lap_n, key_clear_n, key_start_n};

  // Two-stage synchronizer in front of every button; idle level is released (1)
  always_comb begin
    sync1_d = key_raw;
    sync2_d = sync1_q;
  end

  // Debounce counters: only an unbroken run of differing samples moves the
  // accepted level, and a press is the registered falling edge of that level
  always_comb begin
    db_d      = db_q;
    db_prev_d = db_q;
    press_d   = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      cnt_d[k] = cnt_q[k];
      if (sync2_q[k] == db_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CNT_LAST) begin
        db_d[k]  = sync2_q[k];
        cnt_d[k] = '0;
      end else begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
      press_d[k] = db_prev_q[k] & ~db_q[k];
    end
  end

  // Key path registers; reset treats every key as released and settled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      db_q      <= '1;
      db_prev_q <= '1;
      press_q   <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      press_q   <= press_d;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Event arbitration: start beats clear beats lap, losers are discarded
  // ---------------------------------------------------------------------
  logic start_ev;
  logic clear_ev;
  logic lap_ev;

  assign start_ev = press_q[KEY_START];
  assign clear_ev = press_q[KEY_CLEAR] & ~press_q[KEY_START];
  assign lap_ev   = press_q[KEY_LAP] & ~press_q[KEY_CLEAR] & ~press_q[KEY_START];

  // ---------------------------------------------------------------------
  // Run state machine and one-second divider
  // ---------------------------------------------------------------------
  state_t           state_q, state_d;
  logic             count_en_q, count_en_d;
  logic             clear_q, clear_d;
  logic             lap_hold_q, lap_hold_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             counting;

  assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);

  // Next-state, output and divider decode; clear only exists from IDLE/PAUSE,
  // where the divider is idle, so it can never coincide with count_en
  always_comb begin
    state_d    = state_q;
    clear_d    = 1'b0;
    count_en_d = 1'b0;
    div_d      = div_q;

    case (state_q)
      ST_IDLE: begin
        if (start_ev) begin
          state_d = ST_RUN;
        end else if (clear_ev) begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (start_ev) begin
          state_d = ST_PAUSE;
        end else if (lap_ev) begin
          state_d = ST_LAP;
        end
      end
      ST_LAP: begin
        if (start_ev) begin
          state_d = ST_PAUSE;
        end else if (lap_ev) begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (start_ev) begin
          state_d = ST_RUN;
        end else if (clear_ev) begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    lap_hold_d = (state_d == ST_LAP);

    if ((state_q == ST_IDLE) || clear_d) begin
      div_d = '0;
    end else if (counting) begin
      if (div_q == DIV_LAST) begin
        div_d      = '0;
        count_en_d = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // State, divider and all outputs are registered together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      count_en_q <= 1'b0;
      clear_q    <= 1'b0;
      lap_hold_q <= 1'b0;
      div_q      <= '0;
    end else begin
      state_q    <= state_d;
      count_en_q <= count_en_d;
      clear_q    <= clear_d;
      lap_hold_q <= lap_hold_d;
      div_q      <= div_d;
    end
  end

  assign count_en = count_en_q;
  assign clear    = clear_q;
  assign lap_hold = lap_hold_q;
  assign state    = state_q;

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// tb_stop_watch_ctrl: scenario bench for stop_watch_ctrl with a short debounce
// and a fast tick. The expected count_en and clear pulse cycles are queued
// when the causing key press is driven. A negedge monitor pops each entry
// and matches it against the observed pulse.
module tb_stop_watch_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned DIV = 10;

  localparam logic [2:0] K_START = 3'b001;
  localparam logic [2:0] K_CLEAR = 3'b010;
  localparam logic [2:0] K_LAP   = 3'b100;
  localparam logic [2:0] K_ALL   = 3'b111;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_LAP   = 2'b11;

  logic       clk;
  logic       rst_n;
  logic [2:0] keys_n;
  logic       count_en;
  logic       clear;
  logic       lap_hold;
  logic [1:0] state;

  int cyc;
  int n_checks;
  int n_fail;
  int run_start;
  int tick_q[$];
  int clr_q[$];

  stop_watch_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .TICK_DIV       (DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_start_n(keys_n[0]),
    .key_clear_n(keys_n[1]),
    .key_lap_n  (keys_n[2]),
    .count_en   (count_en),
    .clear      (clear),
    .lap_hold   (lap_hold),
    .state      (state)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Posedge count; at a negedge it equals the number of active edges so far
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer for the pulse outputs
  always @(negedge clk) begin
    int e;
    if (count_en) begin
      n_checks++;
      if (tick_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL tick_unexpected: count_en high at cycle %0d, none expected", cyc);
      end else begin
        e = tick_q.pop_front();
        if (e !== cyc) begin
          n_fail++;
          $display("[TB] FAIL tick_cycle: count_en at cycle %0d, expected cycle %0d", cyc, e);
        end
      end
    end else if (tick_q.size() != 0 && tick_q[0] <= cyc) begin
      e = tick_q.pop_front();
      n_checks++;
      n_fail++;
      $display("[TB] FAIL tick_missing: count_en low at cycle %0d, expected pulse at %0d", cyc, e);
    end

    if (clear) begin
      n_checks++;
      if (clr_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL clear_unexpected: clear high at cycle %0d, none expected", cyc);
      end else begin
        e = clr_q.pop_front();
        if (e !== cyc) begin
          n_fail++;
          $display("[TB] FAIL clear_cycle: clear at cycle %0d, expected cycle %0d", cyc, e);
        end
      end
    end else if (clr_q.size() != 0 && clr_q[0] <= cyc) begin
      e = clr_q.pop_front();
      n_checks++;
      n_fail++;
      $display("[TB] FAIL clear_missing: clear low at cycle %0d, expected pulse at %0d", cyc, e);
    end

    if (count_en || clear) begin
      n_checks++;
      if ((count_en && clear) !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL pulse_overlap: count_en=%0b clear=%0b, required not both", count_en, clear);
      end
    end
  end

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Hold the masked keys low for low_cycles rising edges, starting now
  task automatic press(input logic [2:0] mask, input int low_cycles);
    keys_n = keys_n & ~mask;
    repeat (low_cycles) @(negedge clk);
    keys_n = keys_n | mask;
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    keys_n = 3'b000;
    repeat (3) @(negedge clk);
    n_checks++; if (state !== S_IDLE) begin n_fail++; $display("[TB] FAIL reset_state: got %b expected %b", state, S_IDLE); end
    n_checks++; if (count_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_count_en: got %b expected 0", count_en); end
    n_checks++; if (clear !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_clear: got %b expected 0", clear); end
    n_checks++; if (lap_hold !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_lap_hold: got %b expected 0", lap_hold); end
    keys_n = 3'b111;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_until(cyc + 20);
    n_checks++; if (state !== S_IDLE) begin n_fail++; $display("[TB] FAIL reset_release_state: got %b expected %b", state, S_IDLE); end
  endtask

  task automatic test_debounce;
    int c0;
    c0 = cyc;
    press(K_START, DEB - 1);
    wait_until(c0 + 15);
    n_checks++; if (state !== S_IDLE) begin n_fail++; $display("[TB] FAIL glitch_state: got %b expected %b", state, S_IDLE); end

    // Clean press: pulse on cycle c0+7, new state visible on c0+8
    c0 = cyc;
    tick_q.push_back(c0 + 8 + 10);
    tick_q.push_back(c0 + 8 + 20);
    keys_n[0] = 1'b0;
    repeat (7) @(negedge clk);
    n_checks++; if (state !== S_IDLE) begin n_fail++; $display("[TB] FAIL press_pulse_cycle_state: got %b expected %b", state, S_IDLE); end
    @(negedge clk);
    n_checks++; if (state !== S_RUN) begin n_fail++; $display("[TB] FAIL press_run_state: got %b expected %b", state, S_RUN); end
    keys_n[0] = 1'b1;
    run_start = cyc;
  endtask

  task automatic test_tick;
    int r;
    r = run_start;
    wait_until(r + 17);
    press(K_START, 8);
    n_checks++; if (state !== S_PAUSE) begin n_fail++; $display("[TB] FAIL tick_pause_state: got %b expected %b", state, S_PAUSE); end
    n_checks++; if (tick_q.size() !== 0) begin n_fail++; $display("[TB] FAIL tick_pending_at_pause: got %0d entries expected 0", tick_q.size()); end
    wait_until(r + 35);
    // Divider froze at 5 in PAUSE, so the next pulse is 5 cycles after RUN
    tick_q.push_back(cyc + 8 + 5);
    press(K_START, 8);
    n_checks++; if (state !== S_RUN) begin n_fail++; $display("[TB] FAIL tick_resume_state: got %b expected %b", state, S_RUN); end
    run_start = cyc;
  endtask

  task automatic test_clear;
    int s;
    s = run_start;
    tick_q.push_back(s + 15);
    wait_until(s + 6);
    press(K_CLEAR, 8);
    n_checks++; if (state !== S_RUN) begin n_fail++; $display("[TB] FAIL clear_in_run_state: got %b expected %b", state, S_RUN); end
    wait_until(s + 16);
    press(K_START, 8);
    n_checks++; if (state !== S_PAUSE) begin n_fail++; $display("[TB] FAIL clear_pause_state: got %b expected %b", state, S_PAUSE); end
    clr_q.push_back(cyc + 8);
    press(K_CLEAR, 8);
    n_checks++; if (state !== S_IDLE) begin n_fail++; $display("[TB] FAIL clear_idle_state: got %b expected %b", state, S_IDLE); end
    n_checks++; if (lap_hold !== 1'b0) begin n_fail++; $display("[TB] FAIL clear_lap_hold: got %b expected 0", lap_hold); end
    wait_until(s + 40);
    clr_q.push_back(cyc + 8);
    press(K_CLEAR, 8);
    n_checks++; if (state !== S_IDLE) begin n_fail++; $display("[TB] FAIL clear_from_idle_state: got %b expected %b", state, S_IDLE); end
    // Divider was zeroed, so a fresh run needs a full TICK_DIV cycles
    wait_until(s + 50);
    tick_q.push_back(cyc + 8 + 10);
    press(K_START, 8);
    n_checks++; if (state !== S_RUN) begin n_fail++; $display("[TB] FAIL clear_restart_state: got %b expected %b", state, S_RUN); end
    run_start = cyc;
  endtask

  task automatic test_lap;
    int t;
    t = run_start;
    tick_q.push_back(t + 20);
    tick_q.push_back(t + 30);
    wait_until(t + 12);
    press(K_LAP, 8);
    n_checks++; if (state !== S_LAP) begin n_fail++; $display("[TB] FAIL lap_enter_state: got %b expected %b", state, S_LAP); end
    n_checks++; if (lap_hold !== 1'b1) begin n_fail++; $display("[TB] FAIL lap_enter_hold: got %b expected 1", lap_hold); end
    wait_until(t + 32);
    tick_q.push_back(t + 40);
    tick_q.push_back(t + 50);
    press(K_LAP, 8);
    n_checks++; if (state !== S_RUN) begin n_fail++; $display("[TB] FAIL lap_exit_state: got %b expected %b", state, S_RUN); end
    n_checks++; if (lap_hold !== 1'b0) begin n_fail++; $display("[TB] FAIL lap_exit_hold: got %b expected 0", lap_hold); end
    wait_until(t + 46);
    tick_q.push_back(t + 60);
    press(K_LAP, 8);
    n_checks++; if (lap_hold !== 1'b1) begin n_fail++; $display("[TB] FAIL lap_again_hold: got %b expected 1", lap_hold); end
    wait_until(t + 56);
    press(K_START, 8);
    n_checks++; if (state !== S_PAUSE) begin n_fail++; $display("[TB] FAIL lap_to_pause_state: got %b expected %b", state, S_PAUSE); end
    n_checks++; if (lap_hold !== 1'b0) begin n_fail++; $display("[TB] FAIL lap_to_pause_hold: got %b expected 0", lap_hold); end
    run_start = t;
  endtask

  task automatic test_priority;
    int u;
    wait_until(run_start + 70);
    // Divider paused at 4, so the first tick comes 6 cycles into RUN
    u = cyc + 8;
    tick_q.push_back(u + 6);
    tick_q.push_back(u + 16);
    press(K_ALL, 8);
    n_checks++; if (state !== S_RUN) begin n_fail++; $display("[TB] FAIL prio_state: got %b expected %b", state, S_RUN); end
    @(negedge clk);
    n_checks++; if (state !== S_RUN) begin n_fail++; $display("[TB] FAIL prio_state_hold: got %b expected %b", state, S_RUN); end
    run_start = u;
  endtask

  task automatic test_async_reset;
    wait_until(run_start + 16);
    #1;
    n_checks++; if (tick_q.size() !== 0) begin n_fail++; $display("[TB] FAIL pending_ticks: got %0d entries expected 0", tick_q.size()); end
    n_checks++; if (count_en !== 1'b1) begin n_fail++; $display("[TB] FAIL pre_reset_count_en: got %b expected 1", count_en); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (state !== S_IDLE) begin n_fail++; $display("[TB] FAIL async_state: got %b expected %b", state, S_IDLE); end
    n_checks++; if (count_en !== 1'b0) begin n_fail++; $display("[TB] FAIL async_count_en: got %b expected 0", count_en); end
    n_checks++; if ((clear | lap_hold) !== 1'b0) begin n_fail++; $display("[TB] FAIL async_clear_lap: got %b expected 0", clear | lap_hold); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_until(cyc + 5);
    n_checks++; if (state !== S_IDLE) begin n_fail++; $display("[TB] FAIL post_reset_state: got %b expected %b", state, S_IDLE); end
    n_checks++; if (clr_q.size() !== 0) begin n_fail++; $display("[TB] FAIL pending_clears: got %0d entries expected 0", clr_q.size()); end
  endtask

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    keys_n   = 3'b111;
    test_reset();
    $display("[TB] reset done");
    test_debounce();
    test_tick();
    test_clear();
    test_lap();
    test_priority();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation reached time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
